load_store_unit: RTL and testbench

- Memory-access stage between the ALU and the write-back mux.
- Takes the ALU result as the effective address and the rs2 value as store data.
- Runs one request/acknowledge transaction per load/store on a 32-bit data bus and stalls the core until the transaction finishes.
- Returns a sign- or zero-extended ReadData that the write-back mux selects when ResultSrc=1.

---
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_load_store_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one request/acknowledge bus transaction per load or store, with a core stall and a timeout.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of silently masking the address.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_ADDR     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] StoreData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusByteEn,
    input  logic [31:0] BusRData,
    input  logic        BusAck,
    output logic        BusErr,
    output logic        Misaligned
);

    // state | meaning
    // IDLE  | no access in flight; a load/store request is latched onto the bus registers
    // REQ   | BusReq held, waiting for BusAck or the timeout
    // DONE  | result valid for write-back, stall released
    typedef enum logic [1:0] {IDLE, REQ, DONE} stateT;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} sizeT;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    stateT       state;
    logic [15:0] timeoutCnt;
    logic [2:0]  accFunct3;
    logic [1:0]  accOff;
    logic        accLoad;
    logic [1:0]  off;
    sizeT        reqSize;
    logic        trapHit;

    function automatic sizeT accessSize(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: accessSize = SZ_BYTE;
            3'b001, 3'b101: accessSize = SZ_HALF;
            default:        accessSize = SZ_WORD;
        endcase
    endfunction

    function automatic logic [3:0] laneEnable(input sizeT sz, input logic [1:0] o);
        case (sz)
            SZ_BYTE: laneEnable = 4'b0001 << o;
            SZ_HALF: laneEnable = 4'b0011 << {o[1], 1'b0};
            default: laneEnable = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] laneData(input sizeT sz, input logic [31:0] d);
        case (sz)
            SZ_BYTE: laneData = {4{d[7:0]}};
            SZ_HALF: laneData = {2{d[15:0]}};
            default: laneData = d;
        endcase
    endfunction

    // Funct3[2] marks the unsigned load variants
    function automatic logic [31:0] formatLoad(input logic [2:0] f3, input logic [1:0] o,
                                               input logic [31:0] rdata);
        logic [7:0]  lane8;
        logic [15:0] lane16;
        logic        signExt;
        lane8   = rdata[{o, 3'b000} +: 8];
        lane16  = rdata[{o[1], 4'b0000} +: 16];
        signExt = ~f3[2];
        case (accessSize(f3))
            SZ_BYTE: formatLoad = {{24{signExt & lane8[7]}}, lane8};
            SZ_HALF: formatLoad = {{16{signExt & lane16[15]}}, lane16};
            default: formatLoad = rdata;
        endcase
    endfunction

    assign off     = ALUResult[1:0];
    assign reqSize = accessSize(Funct3);

`ifdef MISALIGN_TRAP_EN
    assign trapHit = (reqSize == SZ_HALF && off[0]) || (reqSize == SZ_WORD && off != 2'b00);
`else
    assign trapHit    = 1'b0;
    assign Misaligned = 1'b0;
`endif

    always_comb begin
        Stall = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    Stall = MemRead | MemWrite;
                REQ:     Stall = 1'b1;
                default: Stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ReadData   <= 32'h0;
            BusReq     <= 1'b0;
            BusWe      <= 1'b0;
            BusAddr    <= RESET_ADDR;
            BusWData   <= 32'h0;
            BusByteEn  <= 4'h0;
            BusErr     <= 1'b0;
            timeoutCnt <= 16'h0;
            accFunct3  <= 3'b000;
            accOff     <= 2'b00;
            accLoad    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            Misaligned <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (MemRead | MemWrite) begin
                        accFunct3 <= Funct3;
                        accOff    <= off;
                        accLoad   <= ~MemWrite;
                        if (trapHit) begin
                            ReadData <= 32'h0;
                            state    <= DONE;
`ifdef MISALIGN_TRAP_EN
                            Misaligned <= 1'b1;
`endif
                        end else begin
                            BusAddr   <= {ALUResult[31:2], 2'b00};
                            BusByteEn <= laneEnable(reqSize, off);
                            BusWData  <= laneData(reqSize, StoreData);
                            BusWe     <= MemWrite;
                            BusReq    <= 1'b1;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    // an ack in the final timeout cycle still completes the access
                    if (BusAck) begin
                        if (accLoad) ReadData <= formatLoad(accFunct3, accOff, BusRData);
                        BusReq <= 1'b0;
                        state  <= DONE;
                    end else if (timeoutCnt == TIMEOUT_LAST) begin
                        BusErr   <= 1'b1;
                        ReadData <= 32'h0;
                        BusReq   <= 1'b0;
                        state    <= DONE;
                    end else begin
                        timeoutCnt <= timeoutCnt + 16'd1;
                    end
                end
                DONE: begin
                    timeoutCnt <= 16'h0;
                    BusByteEn  <= 4'h0;
                    BusWe      <= 1'b0;
                    state      <= IDLE;
`ifdef MISALIGN_TRAP_EN
                    Misaligned <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: randomized loads/stores with a bus responder and an arithmetic reference model.
// Honours MISALIGN_TRAP_EN in the model when the design is built with it.
module tb_load_store_unit;
    localparam int          T        = 4;
    localparam logic [31:0] RST_ADDR = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] ALUResult = 32'h0, StoreData = 32'h0;
    logic [31:0] ReadData;
    logic        Stall, BusReq, BusWe, BusErr, Misaligned;
    logic [31:0] BusAddr, BusWData;
    logic [3:0]  BusByteEn;
    logic [31:0] BusRData = 32'h0;
    logic        BusAck = 1'b0;

    load_store_unit #(.TIMEOUT_CYCLES(T), .RESET_ADDR(RST_ADDR)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
        .ALUResult(ALUResult), .StoreData(StoreData), .ReadData(ReadData), .Stall(Stall),
        .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusWData(BusWData),
        .BusByteEn(BusByteEn), .BusRData(BusRData), .BusAck(BusAck), .BusErr(BusErr),
        .Misaligned(Misaligned)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [31:0] rd; logic err; logic mis; int req; } doneT;
    typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wd; logic we; } busT;
    doneT scoreQ[$];
    busT  busQ[$];

    int total = 0, passed = 0;
    logic [31:0] mRead = 32'h0;
    logic        mErr = 1'b0;
    int          ackDelay = 0;
    logic [31:0] rdVal = 32'h0;
    bit          manualBus = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic int sizeOf(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic int laneBase(input int sz, input logic [31:0] addr);
        if (sz == 4) return 0;
        if (sz == 2) return int'(addr[1]) * 2;
        return int'(addr[1:0]);
    endfunction

    function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int sz, base;
        longint unsigned v, span;
        sz   = sizeOf(f3);
        base = laneBase(sz, addr);
        span = 64'd1 << (8 * sz);
        v    = (longint'(rdata) >> (8 * base)) % span;
        if (sz < 4 && f3[2] == 1'b0 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic logic [31:0] expWData(input int sz, input logic [31:0] sd);
        if (sz == 1) return 32'(sd[7:0] * 32'h0101_0101);
        if (sz == 2) return 32'(sd[15:0] * 32'h0001_0001);
        return sd;
    endfunction

    // delay: REQ cycle on which BusAck is given; 0 or > T means never
    task automatic doAccess(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [31:0] rdat, input int delay);
        int   sz, reqN;
        bit   trap, acked, done;
        doneT e;
        busT  b;
        sz = sizeOf(f3);
`ifdef MISALIGN_TRAP_EN
        trap = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
`else
        trap = 0;
`endif
        acked = delay >= 1 && delay <= T;
        if (trap) begin
            mRead = 32'h0;
            reqN  = 0;
        end else begin
            b.addr = {addr[31:2], 2'b00};
            b.be   = 4'(((1 << sz) - 1) << laneBase(sz, addr));
            b.wd   = expWData(sz, sd);
            b.we   = wr;
            busQ.push_back(b);
            reqN = acked ? delay : T;
            if (!acked) begin
                mErr  = 1'b1;
                mRead = 32'h0;
            end else if (!wr) begin
                mRead = expLoad(f3, addr, rdat);
            end
        end
        e.rd = mRead; e.err = mErr; e.mis = trap; e.req = reqN;
        scoreQ.push_back(e);
        ackDelay = delay;
        rdVal    = rdat;
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; StoreData = sd;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (!Stall) done = 1;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        check("access_completes", 32'(done), 32'd1);
    endtask

    // bus responder: checks the latched bus fields every REQ cycle and acks on the planned cycle
    initial begin
        busT cur;
        int  reqSeen;
        reqSeen = 0;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (!manualBus) begin
                if (BusReq && !reset) begin
                    reqSeen++;
                    if (reqSeen == 1) begin
                        if (busQ.size() == 0) check("bus_unexpected_req", 32'd1, 32'd0);
                        else cur = busQ.pop_front();
                    end
                    check("bus_addr", BusAddr, cur.addr);
                    check("bus_byteen", 32'(BusByteEn), 32'(cur.be));
                    check("bus_wdata", BusWData, cur.wd);
                    check("bus_we", 32'(BusWe), 32'(cur.we));
                    if (reqSeen == ackDelay) begin
                        BusAck = 1'b1; BusRData = rdVal;
                    end else begin
                        BusAck = 1'b0; BusRData = $urandom;
                    end
                end else begin
                    BusAck  = 1'b0;
                    reqSeen = 0;
                end
            end
        end
    end

    // monitor: a falling Stall marks the DONE cycle
    initial begin
        int   stallRun, reqRun;
        bit   prevStall, afterDone;
        doneT e;
        stallRun = 0; reqRun = 0; prevStall = 0; afterDone = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stallRun = 0; reqRun = 0; prevStall = 0; afterDone = 0;
            end else begin
                if (afterDone) begin
                    check("idle_lanes_cleared", {27'h0, BusWe, BusByteEn}, 32'h0);
                    afterDone = 0;
                end
                if (BusReq) reqRun++;
                if (Stall) stallRun++;
                else if (prevStall) begin
                    if (scoreQ.size() == 0) check("done_unexpected", 32'd1, 32'd0);
                    else begin
                        e = scoreQ.pop_front();
                        check("readdata", ReadData, e.rd);
                        check("buserr", 32'(BusErr), 32'(e.err));
                        check("misaligned", 32'(Misaligned), 32'(e.mis));
                        check("busreq_done", 32'(BusReq), 32'd0);
                        check("req_cycles", 32'(reqRun), 32'(e.req));
                        check("stall_cycles", 32'(stallRun), 32'(e.req + 1));
                    end
                    stallRun = 0; reqRun = 0; afterDone = 1;
                end
                prevStall = Stall;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not reach its end, got %0d/%0d", passed, total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          rd, wr;
        logic [2:0]  f3;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readdata", ReadData, 32'h0);
        check("rst_busreq", 32'(BusReq), 32'd0);
        check("rst_busaddr", BusAddr, RST_ADDR);
        check("rst_lanes", {BusWData[27:0], BusByteEn}, 32'h0);
        check("rst_flags", {28'h0, BusErr, Misaligned, Stall, BusWe}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        doAccess(1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2);
        doAccess(1, 0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_0000, 1);
        doAccess(1, 0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_0000, 1);
        doAccess(0, 1, 3'b001, 32'h0000_0012, 32'h1234_ABCD, 32'h0, 1);
        doAccess(1, 0, 3'b101, 32'h0000_0046, 32'h0, 32'h9ABC_1234, 4);
        doAccess(1, 0, 3'b010, 32'h0000_0102, 32'h0, 32'h1111_2222, 1);
        doAccess(1, 0, 3'b001, 32'h0000_0031, 32'h0, 32'hF00D_8001, 3);
        doAccess(1, 0, 3'b010, 32'h0000_0400, 32'h0, 32'h5555_5555, 0);
        doAccess(1, 1, 3'b000, 32'h0000_0501, 32'h0000_00A7, 32'h0, 2);

        for (int i = 0; i < 80; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0, 1: begin rd = 1; wr = 0; end
                2:    begin rd = 0; wr = 1; end
                default: begin rd = 1; wr = 1; end
            endcase
            doAccess(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 6));
        end

        // reset during the second REQ cycle, then a late ack
        manualBus = 1;
        BusAck = 1'b0;
        @(posedge clk); #1;
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0000_0300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; MemRead = 1'b0;
        @(negedge clk);
        check("rst_mid_stall_forced", 32'(Stall), 32'd0);
        check("rst_mid_busreq_before", 32'(BusReq), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; BusAck = 1'b1; BusRData = 32'h1234_5678;
        check("rst_mid_busreq", 32'(BusReq), 32'd0);
        check("rst_mid_busaddr", BusAddr, RST_ADDR);
        check("rst_mid_lanes", {27'h0, BusWe, BusByteEn}, 32'h0);
        check("rst_mid_wdata", BusWData, 32'h0);
        check("rst_mid_buserr", 32'(BusErr), 32'd0);
        @(posedge clk); #1;
        BusAck = 1'b0;
        @(negedge clk);
        check("rst_late_ack_readdata", ReadData, 32'h0);
        check("rst_late_ack_idle", {30'h0, BusReq, Stall}, 32'h0);
        mRead = 32'h0; mErr = 1'b0;
        manualBus = 0;

        doAccess(1, 0, 3'b000, 32'h0000_0600, 32'h0, 32'h0000_007F, 1);
        doAccess(0, 1, 3'b010, 32'h0000_0604, 32'hCAFE_F00D, 32'h0, 3);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(scoreQ.size() + busQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
